// File: rtl/dot_acc_int8_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dot_acc_int8_pkg
// Description : Shared constants and types for the INT8 dot-product
//               accumulator: INT8/INT16 range limits, the 16-bit signed
//               accumulator word and the result-buffer state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package dot_acc_int8_pkg;

    localparam int INT8_MIN  = -128;
    localparam int INT8_MAX  = 127;
    localparam int INT16_MIN = -32768;
    localparam int INT16_MAX = 32767;

    typedef logic signed [15:0] acc_t;

    typedef enum logic [0:0] {
        BUF_EMPTY = 1'b0,
        BUF_FULL  = 1'b1
    } buf_state_t;

endpackage : dot_acc_int8_pkg
`default_nettype wire

// File: rtl/dot_acc_int8_reg.sv
`default_nettype none
// ============================================================================
// Module      : dot_acc_int8_reg
// Description : Basic register primitive: W-bit flop, asynchronous
//               active-high reset to zero.
// Ports       : clk - clock
//               rst - asynchronous active-high reset
//               d   - next value
//               q   - registered value
// Revision    : 1.0 - initial release
// ============================================================================
module dot_acc_int8_reg #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else begin
            q <= d;
        end
    end

endmodule : dot_acc_int8_reg
`default_nettype wire

// File: rtl/dot_acc_int8_sat_add16.sv
`default_nettype none
// ============================================================================
// Module      : sat_add16
// Description : Combinational 16-bit signed adder. Reports signed overflow;
//               with DOT_ACC_SAT_EN defined the sum clamps to the INT16
//               limits on overflow, otherwise it wraps (two's complement).
// Ports       : a, b - signed operands
//               sum  - result (saturated or wrapped)
//               ovf  - signed overflow of the raw add
// Config      : DOT_ACC_SAT_EN - enables saturation
// Revision    : 1.0 - initial release
// ============================================================================
module sat_add16
    import dot_acc_int8_pkg::*;
(
    input  acc_t a,
    input  acc_t b,
    output acc_t sum,
    output logic ovf
);

    acc_t raw_sum;

    always_comb begin
        raw_sum = a + b;
        // Overflow only when both operands share a sign the result lacks.
        ovf     = (a[15] == b[15]) && (raw_sum[15] != a[15]);
`ifdef DOT_ACC_SAT_EN
        if (ovf) begin
            sum = a[15] ? acc_t'(INT16_MIN) : acc_t'(INT16_MAX);
        end else begin
            sum = raw_sum;
        end
`else
        sum = raw_sum;
`endif
    end

endmodule : sat_add16
`default_nettype wire

// File: rtl/dot_acc_int8.sv
`default_nettype none
// ============================================================================
// Module      : dot_acc_int8
// Description : Accumulates LEN signed INT8 products into a signed 16-bit
//               dot product and presents each result through a one-entry
//               valid/ready buffer. The input side never stalls: a result
//               finishing while the buffer is full and not being popped is
//               dropped and flagged on the sticky ovf output.
// Ports       : clk, rst          - clock, async active-high reset
//               in_val, in_data   - product stream (signed INT8)
//               clr               - synchronous abort of current vector
//               out_val, out_rdy  - result handshake
//               out_data          - signed 16-bit dot product
//               ovf               - sticky dropped-result flag
//               sat               - buffered result saturated
// Config      : DOT_ACC_SAT_EN - saturating accumulation; sat is 0 when
//               undefined.
// Revision    : 1.0 - initial release
// ============================================================================
module dot_acc_int8
    import dot_acc_int8_pkg::*;
#(
    parameter int LEN   = 4,
    parameter int CNT_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_val,
    input  logic [7:0]  in_data,
    input  logic        clr,
    output logic        out_val,
    input  logic        out_rdy,
    output logic [15:0] out_data,
    output logic        ovf,
    output logic        sat
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(LEN - 1);
`ifdef DOT_ACC_SAT_EN
    localparam logic SAT_EN = 1'b1;
`else
    localparam logic SAT_EN = 1'b0;
`endif

    acc_t             acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sat_run_q, sat_run_d;
    buf_state_t       buf_state_q, buf_state_d;
    logic             buf_state_raw_q;
    acc_t             out_data_q, out_data_d;
    logic             ovf_q, ovf_d;
    logic             sat_q, sat_d;

    acc_t             add_sum;
    logic             add_ovf;
    logic             accept;
    logic             last;
    logic             pop;
    logic             load;

    sat_add16 u_add (
        .a   (acc_q),
        .b   ({{8{in_data[7]}}, in_data}),
        .sum (add_sum),
        .ovf (add_ovf)
    );

    assign buf_state_q = buf_state_t'(buf_state_raw_q);

    always_comb begin
        accept = in_val && !clr;
        last   = accept && (cnt_q == LAST_IDX);
        pop    = (buf_state_q == BUF_FULL) && out_rdy;
        // A completing vector may land in the buffer when it is empty or
        // being drained on this same edge (replace with no bubble).
        load   = last && ((buf_state_q == BUF_EMPTY) || pop);
    end

    // Accumulator, element counter and running-saturation flag
    always_comb begin
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        sat_run_d = sat_run_q;
        if (clr) begin
            acc_d     = '0;
            cnt_d     = '0;
            sat_run_d = 1'b0;
        end else if (accept) begin
            if (last) begin
                acc_d     = '0;
                cnt_d     = '0;
                sat_run_d = 1'b0;
            end else begin
                acc_d     = add_sum;
                cnt_d     = cnt_q + CNT_W'(1);
                sat_run_d = sat_run_q | add_ovf;
            end
        end
    end

    // Output buffer
    always_comb begin
        buf_state_d = buf_state_q;
        out_data_d  = out_data_q;
        sat_d       = sat_q;
        ovf_d       = ovf_q | (last && !load);
        if (load) begin
            buf_state_d = BUF_FULL;
            out_data_d  = add_sum;
            sat_d       = SAT_EN & (sat_run_q | add_ovf);
        end else if (pop) begin
            buf_state_d = BUF_EMPTY;
        end
    end

    dot_acc_int8_reg #(.W(16))    u_acc_reg     (.clk(clk), .rst(rst), .d(acc_d),      .q(acc_q));
    dot_acc_int8_reg #(.W(CNT_W)) u_cnt_reg     (.clk(clk), .rst(rst), .d(cnt_d),      .q(cnt_q));
    dot_acc_int8_reg #(.W(1))     u_sat_run_reg (.clk(clk), .rst(rst), .d(sat_run_d),  .q(sat_run_q));
    dot_acc_int8_reg #(.W(1))     u_buf_st_reg  (.clk(clk), .rst(rst), .d(buf_state_d), .q(buf_state_raw_q));
    dot_acc_int8_reg #(.W(16))    u_data_reg    (.clk(clk), .rst(rst), .d(out_data_d), .q(out_data_q));
    dot_acc_int8_reg #(.W(1))     u_ovf_reg     (.clk(clk), .rst(rst), .d(ovf_d),      .q(ovf_q));
    dot_acc_int8_reg #(.W(1))     u_sat_reg     (.clk(clk), .rst(rst), .d(sat_d),      .q(sat_q));

    assign out_val  = (buf_state_q == BUF_FULL);
    assign out_data = out_data_q;
    assign ovf      = ovf_q;
    assign sat      = sat_q;

endmodule : dot_acc_int8
`default_nettype wire

// File: tb/tb_dot_acc_int8.sv
`default_nettype none
// ============================================================================
// Module      : tb_dot_acc_int8
// Description : Directed self-checking bench for dot_acc_int8. Four
//               instances share one stimulus stream: LEN=4 (main), LEN=1,
//               LEN=256 and LEN=258.
// Config      : DOT_ACC_SAT_EN - selects expected values for the LEN=258
//               negative-overflow vector.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dot_acc_int8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_val = 1'b0;
    logic signed [7:0] in_data = '0;
    logic              clr = 1'b0;
    logic              out_rdy = 1'b1;

    logic        m_val, m_ovf, m_sat;
    logic [15:0] m_data;
    logic        s_val, s_ovf, s_sat;
    logic [15:0] s_data;
    logic        a_val, a_ovf, a_sat;
    logic [15:0] a_data;
    logic        b_val, b_ovf, b_sat;
    logic [15:0] b_data;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dot_acc_int8 #(.LEN(4), .CNT_W(8)) u_dut (
        .clk(clk), .rst(rst), .in_val(in_val), .in_data(in_data), .clr(clr),
        .out_val(m_val), .out_rdy(out_rdy), .out_data(m_data), .ovf(m_ovf), .sat(m_sat)
    );
    dot_acc_int8 #(.LEN(1), .CNT_W(1)) u_len1 (
        .clk(clk), .rst(rst), .in_val(in_val), .in_data(in_data), .clr(clr),
        .out_val(s_val), .out_rdy(out_rdy), .out_data(s_data), .ovf(s_ovf), .sat(s_sat)
    );
    dot_acc_int8 #(.LEN(256), .CNT_W(8)) u_len256 (
        .clk(clk), .rst(rst), .in_val(in_val), .in_data(in_data), .clr(clr),
        .out_val(a_val), .out_rdy(out_rdy), .out_data(a_data), .ovf(a_ovf), .sat(a_sat)
    );
    dot_acc_int8 #(.LEN(258), .CNT_W(9)) u_len258 (
        .clk(clk), .rst(rst), .in_val(in_val), .in_data(in_data), .clr(clr),
        .out_val(b_val), .out_rdy(out_rdy), .out_data(b_data), .ovf(b_ovf), .sat(b_sat)
    );

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    // Apply inputs, take one rising edge, settle 1 time unit past it.
    task automatic step(input logic v, input logic signed [7:0] d, input logic c);
        in_val  = v;
        in_data = d;
        clr     = c;
        @(posedge clk);
        #1;
    endtask

    task automatic rst_pulse();
        #2;
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    initial begin
        // Reset state
        #12;
        chk1 ("rst_out_val", m_val, 1'b0);
        chk16("rst_out_data", m_data, 16'h0000);
        chk1 ("rst_ovf", m_ovf, 1'b0);
        chk1 ("rst_sat", m_sat, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 1. Basic vector 3,-2,5,10 -> 16
        out_rdy = 1'b1;
        step(1'b1, 8'sd3, 1'b0);
        step(1'b1, -8'sd2, 1'b0);
        step(1'b1, 8'sd5, 1'b0);
        chk1 ("basic_no_early_val", m_val, 1'b0);
        step(1'b1, 8'sd10, 1'b0);
        chk1 ("basic_out_val", m_val, 1'b1);
        chk16("basic_out_data", m_data, 16'd16);
        chk1 ("len1_val", s_val, 1'b1);
        chk16("len1_data", s_data, 16'd10);
        step(1'b0, 8'sd0, 1'b0);
        chk1 ("basic_val_drop", m_val, 1'b0);
        chk16("basic_data_kept", m_data, 16'd16);

        // 2. Back-to-back {1,1,1,1} then {-1,-1,-1,-1}
        for (int i = 0; i < 4; i++) step(1'b1, 8'sd1, 1'b0);
        chk16("b2b_first", m_data, 16'd4);
        for (int i = 0; i < 4; i++) step(1'b1, -8'sd1, 1'b0);
        chk1 ("b2b_second_val", m_val, 1'b1);
        chk16("b2b_second", m_data, 16'hFFFC);
        chk1 ("b2b_ovf", m_ovf, 1'b0);
        chk16("len1_push_pop", s_data, 16'hFFFF);
        chk1 ("len1_no_ovf", s_ovf, 1'b0);
        step(1'b0, 8'sd0, 1'b0);
        chk1 ("b2b_drained", m_val, 1'b0);

        // 3. Backpressure: 16 held, next result dropped, ovf sticky
        out_rdy = 1'b0;
        step(1'b1, 8'sd3, 1'b0);
        step(1'b1, -8'sd2, 1'b0);
        step(1'b1, 8'sd5, 1'b0);
        step(1'b1, 8'sd10, 1'b0);
        chk1 ("bp_ovf_before", m_ovf, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 8'sd1, 1'b0);
        chk1 ("bp_val_held", m_val, 1'b1);
        chk16("bp_data_held", m_data, 16'd16);
        chk1 ("bp_ovf", m_ovf, 1'b1);
        chk16("len1_held", s_data, 16'd3);
        chk1 ("len1_ovf", s_ovf, 1'b1);
        out_rdy = 1'b1;
        step(1'b0, 8'sd0, 1'b0);
        chk1 ("bp_popped", m_val, 1'b0);
        chk16("bp_pop_data", m_data, 16'd16);

        // 4. clr mid-vector
        step(1'b1, 8'sd7, 1'b0);
        step(1'b1, 8'sd7, 1'b0);
        step(1'b1, 8'sd9, 1'b1);
        chk1 ("clr_no_val", m_val, 1'b0);
        chk1 ("clr_ovf_kept", m_ovf, 1'b1);
        step(1'b1, 8'sd1, 1'b0);
        step(1'b1, 8'sd2, 1'b0);
        step(1'b1, 8'sd3, 1'b0);
        step(1'b1, 8'sd4, 1'b0);
        chk1 ("clr_val", m_val, 1'b1);
        chk16("clr_data", m_data, 16'd10);

        // 6. Async reset mid-vector
        step(1'b1, 8'sd2, 1'b0);
        step(1'b1, 8'sd2, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk1 ("arst_val", m_val, 1'b0);
        chk16("arst_data", m_data, 16'h0000);
        chk1 ("arst_ovf", m_ovf, 1'b0);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) step(1'b1, 8'sd2, 1'b0);
        chk1 ("arst_next_val", m_val, 1'b1);
        chk16("arst_next_data", m_data, 16'd8);

        // 5. Long vectors: 127s
        rst_pulse();
        for (int i = 0; i < 258; i++) begin
            step(1'b1, 8'sd127, 1'b0);
            if (i == 255) begin
                chk1 ("l256_pos_val", a_val, 1'b1);
                chk16("l256_pos_data", a_data, 16'd32512);
                chk1 ("l256_pos_sat", a_sat, 1'b0);
            end
        end
        chk1 ("l258_pos_val", b_val, 1'b1);
        chk16("l258_pos_data", b_data, 16'd32766);
        chk1 ("l258_pos_sat", b_sat, 1'b0);

        // 5. Long vectors: -128s
        rst_pulse();
        for (int i = 0; i < 258; i++) begin
            step(1'b1, 8'sh80, 1'b0);
            if (i == 255) begin
                chk16("l256_neg_data", a_data, 16'h8000);
                chk1 ("l256_neg_sat", a_sat, 1'b0);
            end
        end
        chk1 ("l258_neg_val", b_val, 1'b1);
`ifdef DOT_ACC_SAT_EN
        chk16("l258_neg_data", b_data, 16'h8000);
        chk1 ("l258_neg_sat", b_sat, 1'b1);
`else
        chk16("l258_neg_data", b_data, 16'd32512);
        chk1 ("l258_neg_sat", b_sat, 1'b0);
`endif
        step(1'b0, 8'sd0, 1'b0);
        chk1 ("l258_popped", b_val, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_dot_acc_int8
`default_nettype wire
